// File: rtl/jt053245_pkg.sv
// Shared types and constants for the jt053245 sprite row drawer.
// Horizontal zoom is compiled in only when JT053245_ZOOM_EN is defined.
package jt053245_pkg;

    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} draw_st_e;

    localparam logic [11:0] ZOOM_ONE = 12'h040;
    localparam int          FRAC_W   = 6;
    localparam int          MAX_PXL  = 256;
    localparam int          TILE_PX  = 16;

    // 10.6 fixed-point source position
    typedef logic [15:0] acc_t;

    function automatic logic [11:0] norm_step(input logic [11:0] hz);
        return (hz == 12'd0) ? 12'h001 : hz;
    endfunction

endpackage

// File: rtl/jt053245_draw_if.sv
// Bundle of the drawer's request, ROM and line-buffer signals.
// Handshakes: dr_start is taken only while dr_busy is low; a ROM word is
// transferred on a cycle with rom_cs and rom_ok both high, rom_addr steady until then.
interface jt053245_draw_if;
    import jt053245_pkg::*;

    logic        dr_start;
    logic        dr_busy;
    logic [15:0] code;
    logic [6:0]  attr;
    logic        hflip;
    logic [3:0]  ysub;
    logic [8:0]  hpos;
    logic [11:0] hzoom;
    logic        hz_keep;
    logic [20:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic [10:0] buf_din;
    logic        buf_we;
    draw_st_e    st;

    modport master (
        output dr_start, code, attr, hflip, ysub, hpos, hzoom, hz_keep, rom_ok, rom_data,
        input  dr_busy, rom_addr, rom_cs, buf_addr, buf_din, buf_we, st
    );

    modport slave (
        input  dr_start, code, attr, hflip, ysub, hpos, hzoom, hz_keep, rom_ok, rom_data,
        output dr_busy, rom_addr, rom_cs, buf_addr, buf_din, buf_we, st
    );

endinterface

// File: rtl/jt053245_hzoom.sv
// Horizontal zoom stepper: 10.6 source accumulator, pixel count and the
// residue carried into a continued tile. done flags the last output pixel.
module jt053245_hzoom
    import jt053245_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        keep,
    input  logic        adv,
    input  logic [11:0] step,
    output logic [9:0]  column,
    output logic        done
);

    localparam acc_t ACC_END = acc_t'(TILE_PX << FRAC_W);

    acc_t       acc, residue, acc_nx;
    logic [8:0] cnt;
    logic       past_end;

    assign acc_nx   = acc + acc_t'(step);
    assign past_end = acc_nx >= ACC_END;
    assign column   = acc[15:FRAC_W];
    assign done     = adv && (past_end || cnt == 9'(MAX_PXL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            residue <= '0;
            cnt     <= '0;
        end else if (load) begin
            acc <= keep ? residue : '0;
            cnt <= '0;
        end else if (adv) begin
            acc <= acc_nx;
            cnt <= cnt + 9'd1;
            // A tile cut short by the pixel limit leaves no meaningful residue
            if (done) residue <= past_end ? acc_nx - ACC_END : '0;
        end
    end

endmodule

// File: rtl/jt053245_draw.sv
// Sprite tile-row drawer: fetches a 16-pixel 4bpp row in two ROM words and
// writes opaque pixels to the line buffer, zoomed when JT053245_ZOOM_EN is defined.
module jt053245_draw
    import jt053245_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    jt053245_draw_if.slave  bus
);

    draw_st_e    st_q, st_d;
    logic [63:0] tile;
    logic [6:0]  attr_r;
    logic        hflip_r;
    logic [11:0] step_r, step_in;
    logic [8:0]  col;
    logic        start_ok, fetch_ok, adv, hz_done;
    logic [9:0]  src_col;
    logic [3:0]  pxl_idx, pxl;

    assign start_ok     = (st_q == IDLE) && bus.dr_start;
    assign fetch_ok     = bus.rom_cs && bus.rom_ok;
    assign adv          = (st_q == DRAW);
    assign bus.dr_busy  = (st_q != IDLE);
    assign bus.rom_cs   = (st_q == FETCH0) || (st_q == FETCH1);
    assign bus.st       = st_q;

`ifdef JT053245_ZOOM_EN
    assign step_in = norm_step(bus.hzoom);
`else
    assign step_in = ZOOM_ONE;
`endif

    jt053245_hzoom u_hzoom (
        .clk    (clk),
        .rst    (rst),
        .load   (start_ok),
        .keep   (bus.hz_keep),
        .adv    (adv),
        .step   (step_r),
        .column (src_col),
        .done   (hz_done)
    );

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (bus.dr_start) st_d = FETCH0;
            FETCH0:  if (fetch_ok)     st_d = FETCH1;
            FETCH1:  if (fetch_ok)     st_d = DRAW;
            DRAW:    if (hz_done)      st_d = IDLE;
            default:                   st_d = IDLE;
        endcase
        pxl_idx = hflip_r ? (4'd15 - src_col[3:0]) : src_col[3:0];
        // A continued tile may start past the row end; such columns draw nothing
        pxl     = (src_col < 10'd16) ? tile[{pxl_idx, 2'b00} +: 4] : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= IDLE;
            tile         <= '0;
            attr_r       <= '0;
            hflip_r      <= 1'b0;
            step_r       <= ZOOM_ONE;
            col          <= '0;
            bus.rom_addr <= '0;
            bus.buf_we   <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_din  <= '0;
        end else begin
            st_q       <= st_d;
            bus.buf_we <= 1'b0;
            if (start_ok) begin
                bus.rom_addr <= {bus.code, bus.ysub, 1'b0};
                attr_r       <= bus.attr;
                hflip_r      <= bus.hflip;
                step_r       <= step_in;
                if (!bus.hz_keep) col <= bus.hpos;
            end
            if (st_q == FETCH0 && fetch_ok) begin
                tile[31:0]      <= bus.rom_data;
                bus.rom_addr[0] <= 1'b1;
            end
            if (st_q == FETCH1 && fetch_ok) tile[63:32] <= bus.rom_data;
            if (adv) begin
                col          <= col + 9'd1;
                bus.buf_addr <= col;
                bus.buf_din  <= {attr_r, pxl};
                bus.buf_we   <= (pxl != 4'd0);
            end
        end
    end

endmodule

// File: tb/tb_jt053245_draw.sv
// Directed bench for jt053245_draw; expected writes come from a pixel-level
// model of the zoom rules (JT053245_ZOOM_EN selects which rules apply).
module tb_jt053245_draw;
    import jt053245_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt053245_draw_if bus();

    jt053245_draw dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {busy after the write, column, attr, pixel}
    logic [20:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    int          m_res = 0, m_col = 0;
    logic [20:0] m_first, m_last;

    logic [31:0] rom_lo, rom_hi;
    logic [20:0] exp_rom, held;
    int          rom_lat = 0, wait_n = 0, req_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Walk the source position in plain integers and list every opaque write
    function automatic int model_tile(input logic [6:0] attr, input logic hflip,
                                      input logic [8:0] hpos, input logic [11:0] hzoom,
                                      input logic keep, input logic [31:0] lo,
                                      input logic [31:0] hi);
        int step, acc, col, n, sc, nw;
        logic [63:0] w;
        logic [3:0]  px;
        logic        last;
        logic [20:0] e;
        bit          first_set;
`ifdef JT053245_ZOOM_EN
        step = (hzoom == 12'd0) ? 1 : int'(hzoom);
`else
        step = 64;
`endif
        w = {hi, lo};
        acc = keep ? m_res : 0;
        col = keep ? m_col : int'(hpos);
        n = 0; nw = 0; first_set = 0;
        m_first = '0; m_last = '0;
        do begin
            sc = acc / 64;
            px = 4'd0;
            if (sc < 16) px = w[(hflip ? 15 - sc : sc) * 4 +: 4];
            acc = acc + step;
            n++;
            last = (acc >= 1024) || (n == 256);
            e = {~last, 9'(col), attr, px};
            if (px != 4'd0) begin
                exp_q.push_back(e);
                nw++;
                if (!first_set) m_first = e;
                first_set = 1;
            end
            m_last = e;
            col = (col + 1) % 512;
        end while (!last);
        m_res = (acc >= 1024) ? acc - 1024 : 0;
        m_col = col;
        return nw;
    endfunction

    // ROM responder: answers after rom_lat idle cycles, checks address hold
    initial begin
        bus.rom_ok = 1'b0;
        bus.rom_data = '0;
        forever begin
            @(negedge clk);
            bus.rom_ok = 1'b0;
            if (bus.rom_cs && !rst) begin
                if (wait_n == 0) begin
                    held = bus.rom_addr;
                    check("rom_addr", 32'(held), 32'(exp_rom | 21'(req_n)));
                end else begin
                    check("rom_addr_hold", 32'(bus.rom_addr), 32'(held));
                end
                if (wait_n >= rom_lat) begin
                    bus.rom_ok = 1'b1;
                    bus.rom_data = held[0] ? rom_hi : rom_lo;
                    wait_n = 0;
                    req_n++;
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
        end
    end

    // Scoreboard: every write strobe must match the next expected write
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (bus.buf_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {11'd0, bus.dr_busy, bus.buf_addr, bus.buf_din}, 32'h1fffff);
                end else begin
                    e = exp_q.pop_front();
                    check("buf_write", {11'd0, bus.dr_busy, bus.buf_addr, bus.buf_din}, {11'd0, e});
                end
            end
        end
    end

    // mode 0: plain tile, 1: stray dr_start during DRAW, 2: reset during DRAW
    task automatic draw_tile(input string name, input logic [15:0] code, input logic [6:0] attr,
                             input logic hflip, input logic [3:0] ysub, input logic [8:0] hpos,
                             input logic [11:0] hzoom, input logic keep,
                             input logic [31:0] lo, input logic [31:0] hi,
                             input int lat, input int mode, output int nw);
        rom_lo = lo; rom_hi = hi; rom_lat = lat;
        exp_rom = {code, ysub, 1'b0};
        req_n = 0;
        nw = model_tile(attr, hflip, hpos, hzoom, keep, lo, hi);
        @(negedge clk); #1;
        bus.code = code; bus.attr = attr; bus.hflip = hflip; bus.ysub = ysub;
        bus.hpos = hpos; bus.hzoom = hzoom; bus.hz_keep = keep;
        bus.dr_start = 1'b1;
        @(negedge clk);
        check({name, "_busy"}, 32'(bus.dr_busy), 32'd1);
        #1 bus.dr_start = 1'b0;
        if (mode != 0) begin
            for (int i = 0; i < 100 && bus.st != DRAW; i++) @(negedge clk);
            check({name, "_in_draw"}, 32'(bus.st), 32'(DRAW));
            if (mode == 1) begin
                #1;
                bus.dr_start = 1'b1; bus.code = 16'hffff; bus.hpos = 9'h155; bus.hz_keep = 1'b0;
                @(negedge clk); #1 bus.dr_start = 1'b0;
            end else begin
                @(negedge clk); @(negedge clk); #1;
                rst = 1'b1;
                exp_q.delete();
                m_res = 0; m_col = 0;
                @(negedge clk);
                check({name, "_rst_we"}, 32'(bus.buf_we), 32'd0);
                check({name, "_rst_busy"}, 32'(bus.dr_busy), 32'd0);
                check({name, "_rst_cs"}, 32'(bus.rom_cs), 32'd0);
                check({name, "_rst_st"}, 32'(bus.st), 32'(IDLE));
                @(negedge clk);
                check({name, "_rst_we2"}, 32'(bus.buf_we), 32'd0);
                #1 rst = 1'b0;
                return;
            end
        end
        for (int i = 0; i < 600 && bus.dr_busy; i++) @(negedge clk);
        #1;
        check({name, "_done"}, 32'(bus.dr_busy), 32'd0);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    localparam logic [31:0] PAT_A_LO = 32'h7654_3210;
    localparam logic [31:0] PAT_A_HI = 32'hfedc_ba98;
    localparam logic [31:0] PAT_B_LO = 32'h3c2d_1e0f;
    localparam logic [31:0] PAT_B_HI = 32'h8f7e_6d5c;

    initial begin
        int nw;
        bus.dr_start = 1'b0; bus.code = '0; bus.attr = '0; bus.hflip = 1'b0;
        bus.ysub = '0; bus.hpos = '0; bus.hzoom = ZOOM_ONE; bus.hz_keep = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", 32'(bus.dr_busy), 32'd0);
        check("rst_cs", 32'(bus.rom_cs), 32'd0);
        check("rst_we", 32'(bus.buf_we), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        check("rst_buf_din", 32'(bus.buf_din), 32'd0);
        check("rst_state", 32'(bus.st), 32'(IDLE));
        #1 rst = 1'b0;

        draw_tile("one2one", 16'h0012, 7'h55, 1'b0, 4'd3, 9'h020, 12'h040, 1'b0,
                  PAT_A_LO, PAT_A_HI, 0, 0, nw);
        check("one2one_nw", 32'(nw), 32'd15);
        check("one2one_first", 32'(m_first), {11'd0, 1'b1, 9'h021, 7'h55, 4'h1});
        check("one2one_last", 32'(m_last), {11'd0, 1'b0, 9'h02f, 7'h55, 4'hf});

        draw_tile("mirror", 16'h0012, 7'h55, 1'b1, 4'd3, 9'h020, 12'h040, 1'b0,
                  PAT_A_LO, PAT_A_HI, 5, 0, nw);
        check("mirror_nw", 32'(nw), 32'd15);
        check("mirror_first", 32'(m_first), {11'd0, 1'b1, 9'h020, 7'h55, 4'hf});
        check("mirror_last", 32'(m_last), {11'd0, 1'b0, 9'h02f, 7'h55, 4'h0});

        draw_tile("enlarge", 16'h1234, 7'h2a, 1'b0, 4'd7, 9'h080, 12'h020, 1'b0,
                  PAT_A_LO, PAT_A_HI, 1, 0, nw);
`ifdef JT053245_ZOOM_EN
        check("enlarge_nw", 32'(nw), 32'd30);
`else
        check("enlarge_nw", 32'(nw), 32'd15);
`endif

        draw_tile("reduce", 16'h00ab, 7'h11, 1'b0, 4'd0, 9'h0c0, 12'h080, 1'b0,
                  PAT_A_LO, PAT_A_HI, 2, 0, nw);
`ifdef JT053245_ZOOM_EN
        check("reduce_nw", 32'(nw), 32'd7);
        check("reduce_last", 32'(m_last), {11'd0, 1'b0, 9'h0c7, 7'h11, 4'he});
`else
        check("reduce_nw", 32'(nw), 32'd15);
`endif

        draw_tile("stitch_a", 16'h0200, 7'h33, 1'b0, 4'd1, 9'h040, 12'h030, 1'b0,
                  PAT_A_LO, PAT_A_HI, 0, 0, nw);
`ifdef JT053245_ZOOM_EN
        check("stitch_a_res", 32'(m_res), 32'h020);
        check("stitch_a_col", 32'(m_col), 32'h056);
`else
        check("stitch_a_res", 32'(m_res), 32'h000);
        check("stitch_a_col", 32'(m_col), 32'h050);
`endif
        draw_tile("stitch_b", 16'h0201, 7'h33, 1'b0, 4'd1, 9'h100, 12'h030, 1'b1,
                  PAT_A_LO, PAT_A_HI, 0, 0, nw);
`ifdef JT053245_ZOOM_EN
        check("stitch_b_nw", 32'(nw), 32'd20);
        check("stitch_b_col", 32'(m_col), 32'h06b);
`else
        check("stitch_b_nw", 32'(nw), 32'd15);
        check("stitch_b_col", 32'(m_col), 32'h060);
`endif

        draw_tile("poke", 16'h0345, 7'h7f, 1'b0, 4'ha, 9'h100, 12'h040, 1'b0,
                  PAT_B_LO, PAT_B_HI, 0, 1, nw);
        check("poke_nw", 32'(nw), 32'd15);

        draw_tile("wrap", 16'h0012, 7'h05, 1'b0, 4'd3, 9'h1f8, 12'h040, 1'b0,
                  PAT_A_LO, PAT_A_HI, 0, 0, nw);
        check("wrap_first", 32'(m_first), {11'd0, 1'b1, 9'h1f9, 7'h05, 4'h1});
        check("wrap_last", 32'(m_last), {11'd0, 1'b0, 9'h007, 7'h05, 4'hf});

        draw_tile("reset", 16'h0012, 7'h55, 1'b0, 4'd3, 9'h020, 12'h040, 1'b0,
                  PAT_A_LO, PAT_A_HI, 0, 2, nw);

        draw_tile("after_rst", 16'h0777, 7'h44, 1'b0, 4'd2, 9'h0f0, 12'h040, 1'b1,
                  PAT_B_LO, PAT_B_HI, 3, 0, nw);
        check("after_rst_first", 32'(m_first), {11'd0, 1'b1, 9'h000, 7'h44, 4'hf});

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
